// File: rtl/commit_trace_tx.sv
// Commit trace transmitter: queues retired register writes from the core's debug
// writeback port and streams each one as a 10-byte frame over a valid/ready byte link.
module commit_trace_tx #(
    parameter int DEPTH      = 16,
    parameter int CAPTURE_X0 = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trace_en,
    input  logic [31:0]              debug_wb_pc,
    input  logic                     debug_wb_ena,
    input  logic [4:0]               debug_wb_reg,
    input  logic [31:0]              debug_wb_value,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              drop_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic        ovf;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] value;
    } entry_t;

    entry_t         mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic [15:0]    drop_q, drop_d;
    logic           pend_ovf_q, pend_ovf_d;
    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    entry_t         shadow_q, shadow_d;

    logic cap, pop, push, drop;

    function automatic logic [7:0] frame_byte(input entry_t e, input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'hA5;
            4'd1:    return {e.ovf, 2'b00, e.rd};
            4'd2:    return e.pc[7:0];
            4'd3:    return e.pc[15:8];
            4'd4:    return e.pc[23:16];
            4'd5:    return e.pc[31:24];
            4'd6:    return e.value[7:0];
            4'd7:    return e.value[15:8];
            4'd8:    return e.value[23:16];
            4'd9:    return e.value[31:24];
            default: return 8'h00;
        endcase
    endfunction

    // Serialiser: pops in IDLE, so a full FIFO can still accept a commit that cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        pop      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    pop      = 1'b1;
                    shadow_d = mem_q[rd_ptr_q];
                    idx_d    = 4'd0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = frame_byte(shadow_q, idx_q);
                if (tx_ready) begin
                    if (idx_q == 4'd9) state_d = IDLE;
                    else               idx_d   = idx_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cap  = trace_en && debug_wb_ena && ((CAPTURE_X0 != 0) || (debug_wb_reg != 5'd0));
        push = cap && ((level_q < FULL_LEVEL) || pop);
        drop = cap && !push;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

        if (push)      pend_ovf_d = 1'b0;
        else if (drop) pend_ovf_d = 1'b1;
        else           pend_ovf_d = pend_ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 4'd0;
            shadow_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= 16'd0;
            pend_ovf_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            pend_ovf_q <= pend_ovf_d;
        end
    end

    // NOTE: storage is not reset; the level/pointers decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= '{ovf: pend_ovf_q, rd: debug_wb_reg,
                                 pc: debug_wb_pc, value: debug_wb_value};
        end
    end

    assign fifo_level = level_q;
    assign drop_count = drop_q;
    assign busy       = (level_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_commit_trace_tx.sv
// Directed bench for commit_trace_tx: frame format, back-pressure/drops, x0 filtering,
// stall stability, mid-frame reset and the full-FIFO push/pop corner.
module tb_commit_trace_tx;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic          trace_en;
    logic [31:0]   debug_wb_pc;
    logic          debug_wb_ena;
    logic [4:0]    debug_wb_reg;
    logic [31:0]   debug_wb_value;
    logic          tx_ready;

    logic [7:0]    tx_data,   tx_data_x;
    logic          tx_valid,  tx_valid_x;
    logic [LW-1:0] fifo_level, fifo_level_x;
    logic [15:0]   drop_count, drop_count_x;
    logic          busy,      busy_x;

    int vectors     = 0;
    int miscompares = 0;

    commit_trace_tx #(.DEPTH(DEPTH), .CAPTURE_X0(0)) dut (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .debug_wb_pc(debug_wb_pc), .debug_wb_ena(debug_wb_ena),
        .debug_wb_reg(debug_wb_reg), .debug_wb_value(debug_wb_value),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .fifo_level(fifo_level), .drop_count(drop_count), .busy(busy)
    );

    commit_trace_tx #(.DEPTH(DEPTH), .CAPTURE_X0(1)) dut_x0 (
        .clk(clk), .rst(rst), .trace_en(trace_en),
        .debug_wb_pc(debug_wb_pc), .debug_wb_ena(debug_wb_ena),
        .debug_wb_reg(debug_wb_reg), .debug_wb_value(debug_wb_value),
        .tx_data(tx_data_x), .tx_valid(tx_valid_x), .tx_ready(tx_ready),
        .fifo_level(fifo_level_x), .drop_count(drop_count_x), .busy(busy_x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] r, input logic [31:0] pc, input logic [31:0] val);
        debug_wb_ena   = 1'b1;
        debug_wb_reg   = r;
        debug_wb_pc    = pc;
        debug_wb_value = val;
        tick();
        debug_wb_ena   = 1'b0;
    endtask

    // Byte 0 in the low octet, byte 9 in the high octet.
    function automatic logic [79:0] frame(input logic ovf, input logic [4:0] r,
                                          input logic [31:0] pc, input logic [31:0] val);
        return {val, pc, ovf, 2'b00, r, 8'hA5};
    endfunction

    task automatic recv_frame(input logic [79:0] exp, input string tag, input bit toggle);
        int         got   = 0;
        int         cyc   = 0;
        bit         stall = 1'b0;
        logic [7:0] held  = 8'h00;
        while (got < 10 && cyc < 100) begin
            if (toggle) tx_ready = ~cyc[0];
            if (stall) check({tag, " hold"}, {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, held});
            stall = 1'b0;
            if (tx_valid && tx_ready) begin
                check($sformatf("%s b%0d", tag, got), {24'd0, tx_data}, {24'd0, exp[8*got +: 8]});
                got++;
            end else if (tx_valid) begin
                stall = 1'b1;
                held  = tx_data;
            end
            tick();
            cyc++;
        end
        check({tag, " count"}, got, 10);
        tx_ready = 1'b1;
    endtask

    initial begin
        rst            = 1'b1;
        trace_en       = 1'b1;
        debug_wb_ena   = 1'b0;
        debug_wb_reg   = 5'd0;
        debug_wb_pc    = 32'd0;
        debug_wb_value = 32'd0;
        tx_ready       = 1'b1;
        tick();
        tick();
        check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst tx_data", {24'd0, tx_data}, 32'd0);
        check("rst level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
        check("rst drop", {16'd0, drop_count}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // T1: single frame with the sink always ready
        commit(5'd5, 32'h0000_0010, 32'hDEAD_BEEF);
        check("t1 level", {{(32-LW){1'b0}}, fifo_level}, 32'd1);
        check("t1 idle valid", {31'd0, tx_valid}, 32'd0);
        recv_frame(80'hDEADBEEF_00000010_05_A5, "t1", 1'b0);
        check("t1 busy low", {31'd0, busy}, 32'd0);
        check("t1 valid low", {31'd0, tx_valid}, 32'd0);

        // T2/T6: stall, overfill, then a commit into a full FIFO that pops that cycle
        tx_ready = 1'b0;
        commit(5'd1, 32'h0000_0100, 32'h0000_0011);
        tick();
        check("t2 shadow busy", {31'd0, busy}, 32'd1);
        check("t2 level0", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
        for (int i = 0; i < DEPTH + 3; i++) commit(5'd1, 32'h200 + 32'(i), 32'(i));
        check("t2 level full", {{(32-LW){1'b0}}, fifo_level}, DEPTH);
        check("t2 drops", {16'd0, drop_count}, 32'd3);
        check("t2 held sync", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
        tx_ready = 1'b1;
        recv_frame(frame(1'b0, 5'd1, 32'h100, 32'h11), "t2 f0", 1'b0);
        check("t6 pre level", {{(32-LW){1'b0}}, fifo_level}, DEPTH);
        commit(5'd1, 32'h0000_0300, 32'h0000_0033);
        check("t6 level", {{(32-LW){1'b0}}, fifo_level}, DEPTH);
        check("t6 drops", {16'd0, drop_count}, 32'd3);
        for (int i = 0; i < DEPTH; i++)
            recv_frame(frame(1'b0, 5'd1, 32'h200 + 32'(i), 32'(i)), $sformatf("t2 q%0d", i), 1'b0);
        recv_frame(80'h00000033_00000300_81_A5, "t2 ovf", 1'b0);
        check("t2 drained", {{(31-LW){1'b0}}, busy, fifo_level}, 32'd0);

        // T3: x0 writes filtered unless CAPTURE_X0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        commit(5'd0, 32'h0000_0040, 32'h0000_0055);
        check("t3 level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
        check("t3 busy", {31'd0, busy}, 32'd0);
        check("t3 x0 level", {{(32-LW){1'b0}}, fifo_level_x}, 32'd1);
        tick();
        check("t3 valid", {31'd0, tx_valid}, 32'd0);
        check("t3 drop", {16'd0, drop_count}, 32'd0);
        check("t3 x0 sync", {23'd0, tx_valid_x, tx_data_x}, {23'd0, 1'b1, 8'hA5});
        tick();
        check("t3 x0 header", {23'd0, tx_valid_x, tx_data_x}, {23'd0, 1'b1, 8'h00});
        repeat (12) tick();
        check("t3 x0 done", {15'd0, busy_x, drop_count_x}, 32'd0);

        // T4: sink ready toggling every cycle
        commit(5'd7, 32'h1234_5678, 32'h0BAD_F00D);
        recv_frame(80'h0BADF00D_12345678_07_A5, "t4", 1'b1);
        check("t4 busy low", {31'd0, busy}, 32'd0);

        // T5: reset after byte 4 of a frame, then a fresh frame with trace_en dropped mid-frame
        commit(5'd9, 32'hCAFE_0000, 32'h0000_0001);
        commit(5'd10, 32'h0000_BEEF, 32'h0000_0002);
        check("t5 level", {{(32-LW){1'b0}}, fifo_level}, 32'd1);
        repeat (4) tick();
        check("t5 byte4", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hFE});
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 rst valid", {23'd0, tx_valid, tx_data}, 32'd0);
        check("t5 rst level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
        check("t5 rst drop", {16'd0, drop_count}, 32'd0);
        check("t5 rst busy", {31'd0, busy}, 32'd0);
        commit(5'd11, 32'h0000_0080, 32'h0000_0077);
        trace_en = 1'b0;
        recv_frame(80'h00000077_00000080_0B_A5, "t5 new", 1'b0);
        commit(5'd3, 32'h0000_0090, 32'h0000_0099);
        check("en off level", {{(32-LW){1'b0}}, fifo_level}, 32'd0);
        check("en off busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
